// File: rtl/ipm_coord_mapper.sv
// ipm_coord_mapper: pipelined bypass/LUT/flip coordinate remapper with a credit-gated first-word-fall-through output FIFO.
// Define IPM_OOB_DROP_EN to discard out-of-frame beats instead of flagging them on o_oob.
module ipm_coord_mapper #(
  parameter int CAM_DATA_WIDTH = 12,
  parameter int CAM_LINE       = 9,
  parameter int CAM_PIXEL      = 10,
  parameter int FRAME_W        = 640,
  parameter int FRAME_H        = 480,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_valid,
  output logic                          o_ready,
  input  logic [CAM_LINE-1:0]           i_line,
  input  logic [CAM_PIXEL-1:0]          i_pixel,
  input  logic [CAM_DATA_WIDTH-1:0]     i_data,
  input  logic [1:0]                    im_p,
  output logic [CAM_LINE+CAM_PIXEL-1:0] o_lut_addr,
  output logic                          o_lut_en,
  input  logic [CAM_LINE+CAM_PIXEL-1:0] i_lut_data,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [CAM_LINE-1:0]           o_line,
  output logic [CAM_PIXEL-1:0]          o_pixel,
  output logic [CAM_DATA_WIDTH-1:0]     o_data,
  output logic                          o_oob
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CAM_PIXEL:0] PX_LIM = (CAM_PIXEL+1)'(FRAME_W);
  localparam logic [CAM_PIXEL:0] PX_MAX = (CAM_PIXEL+1)'(FRAME_W - 1);
  localparam logic [CAM_LINE:0]  LN_LIM = (CAM_LINE+1)'(FRAME_H);
  localparam logic [CAM_LINE:0]  LN_MAX = (CAM_LINE+1)'(FRAME_H - 1);

  typedef struct packed {
    logic [CAM_LINE-1:0]       line;
    logic [CAM_PIXEL-1:0]      pixel;
    logic [CAM_DATA_WIDTH-1:0] data;
  } src_t;

  typedef struct packed {
    logic [CAM_LINE-1:0]       line;
    logic [CAM_PIXEL-1:0]      pixel;
    logic [CAM_DATA_WIDTH-1:0] data;
    logic                      oob;
  } beat_t;

  logic                rdy_q;
  logic                s0_v_q;
  src_t                s0_q;
  logic [1:0]          s0_mode_q;
  logic                s1_v_q;
  beat_t               s1_q, s1_d;
  beat_t               mem_q [FIFO_DEPTH];
  beat_t               head;
  logic [AW-1:0]       wr_q, rd_q;
  logic [CW-1:0]       cnt_q, occ;
  logic                accept, push, pop;
  logic [CAM_PIXEL:0]  hx;
  logic [CAM_LINE:0]   vy;
  logic [CAM_LINE-1:0] dst_line;
  logic [CAM_PIXEL-1:0] dst_pix;
  logic                oob;

  // Credits cover FIFO entries plus beats still in S0/S1, so the FIFO can never overflow.
  assign occ        = cnt_q + CW'(s0_v_q) + CW'(s1_v_q);
  assign o_ready    = rdy_q & (occ < CW'(FIFO_DEPTH));
  assign accept     = i_valid & o_ready;
  assign o_lut_en   = accept & (im_p == 2'd1);
  assign o_lut_addr = o_lut_en ? {i_line, i_pixel} : '0;

  always_comb begin
    hx       = PX_MAX - {1'b0, s0_q.pixel};
    vy       = LN_MAX - {1'b0, s0_q.line};
    dst_line = (s0_mode_q == 2'd1) ? i_lut_data[CAM_PIXEL +: CAM_LINE] :
               (s0_mode_q == 2'd3) ? vy[CAM_LINE-1:0] : s0_q.line;
    dst_pix  = (s0_mode_q == 2'd1) ? i_lut_data[CAM_PIXEL-1:0] :
               (s0_mode_q == 2'd2) ? hx[CAM_PIXEL-1:0] : s0_q.pixel;
    oob      = ({1'b0, s0_q.line} >= LN_LIM) | ({1'b0, s0_q.pixel} >= PX_LIM)
             | ({1'b0, dst_line} >= LN_LIM) | ({1'b0, dst_pix} >= PX_LIM)
             | ((s0_mode_q == 2'd2) & hx[CAM_PIXEL]) | ((s0_mode_q == 2'd3) & vy[CAM_LINE])
             | ((s0_mode_q == 2'd1) & (&i_lut_data));
    s1_d     = oob ? {{(CAM_LINE+CAM_PIXEL+CAM_DATA_WIDTH){1'b0}}, 1'b1}
                   : {dst_line, dst_pix, s0_q.data, 1'b0};
  end

`ifdef IPM_OOB_DROP_EN
  assign push = s1_v_q & ~s1_q.oob;
`else
  assign push = s1_v_q;
`endif

  assign o_valid = cnt_q != '0;
  assign pop     = o_valid & i_ready;
  assign head    = mem_q[rd_q];
  assign o_line  = o_valid ? head.line : '0;
  assign o_pixel = o_valid ? head.pixel : '0;
  assign o_data  = o_valid ? head.data : '0;
  assign o_oob   = o_valid & head.oob;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q     <= 1'b0;
      s0_v_q    <= 1'b0;
      s0_q      <= '0;
      s0_mode_q <= '0;
      s1_v_q    <= 1'b0;
      s1_q      <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
    end else begin
      rdy_q  <= 1'b1;
      s0_v_q <= accept;
      if (accept) begin
        s0_q      <= {i_line, i_pixel, i_data};
        s0_mode_q <= im_p;
      end
      s1_v_q <= s0_v_q;
      if (s0_v_q) s1_q <= s1_d;
      if (push) wr_q <= wr_q + AW'(1);
      if (pop) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= s1_q;
  end
endmodule

// File: tb/tb_ipm_coord_mapper.sv
// tb_ipm_coord_mapper: directed vector table, backpressure/reset sequences and random traffic against a scoreboard model.
module tb_ipm_coord_mapper;
  localparam int W = 640, H = 480, D = 4, SENT = 'h7FFFF;

  logic        clk = 1'b0, rst_n = 1'b0, i_valid = 1'b0, i_ready = 1'b0;
  logic [8:0]  i_line = '0;
  logic [9:0]  i_pixel = '0;
  logic [11:0] i_data = '0;
  logic [1:0]  im_p = '0;
  logic [18:0] i_lut_data = '0;
  logic [18:0] o_lut_addr;
  logic        o_lut_en, o_ready, o_valid, o_oob;
  logic [8:0]  o_line;
  logic [9:0]  o_pixel;
  logic [11:0] o_data;

  int total = 0, bad = 0, lut_ovr = -1;
  bit chk_credit = 0;

  typedef struct { int line, pix, data, oob; } exp_t;
  typedef struct { int line, pix, data, mode, lut, el, ep, ed, eo; } vec_t;
  exp_t sb[$];

  ipm_coord_mapper dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_line(i_line), .i_pixel(i_pixel), .i_data(i_data), .im_p(im_p),
    .o_lut_addr(o_lut_addr), .o_lut_en(o_lut_en), .i_lut_data(i_lut_data),
    .o_valid(o_valid), .i_ready(i_ready), .o_line(o_line), .o_pixel(o_pixel),
    .o_data(o_data), .o_oob(o_oob)
  );

  always #5 clk = ~clk;

  function automatic int rom_fn(int a);
    return (a % 13 == 0) ? SENT : (a * 37 + 11) % 'h80000;
  endfunction

  function automatic int lut_val(int a);
    return lut_ovr >= 0 ? lut_ovr : rom_fn(a);
  endfunction

  // Synchronous LUT ROM: data appears one cycle after the read strobe.
  always @(posedge clk) if (o_lut_en) i_lut_data <= 19'(lut_val(int'(o_lut_addr)));

  function automatic exp_t model(int ln, int px, int d, int m, int lut);
    exp_t e;
    int dl = ln, dp = px;
    bit bad_c = (ln >= H) || (px >= W);
    if (m == 1) begin dl = lut / 1024; dp = lut % 1024; bad_c |= (lut == SENT); end
    if (m == 2) dp = W - 1 - px;
    if (m == 3) dl = H - 1 - ln;
    bad_c |= (dl < 0) || (dp < 0) || (dl >= H) || (dp >= W);
    e = bad_c ? '{0, 0, 0, 1} : '{dl, dp, d, 0};
    return e;
  endfunction

  task automatic chk(string n, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", n, act, exp);
    end
  endtask

  always begin
    bit acc, pop;
    exp_t e, h, x;
    @(negedge clk); #2;
    acc = rst_n && i_valid && o_ready;
    pop = rst_n && o_valid && i_ready;
    if (chk_credit) chk("credit", int'(o_ready), int'(sb.size() < D));
    e = model(int'(i_line), int'(i_pixel), int'(i_data), int'(im_p), lut_val(int'({i_line, i_pixel})));
    h = '{int'(o_line), int'(o_pixel), int'(o_data), int'(o_oob)};
    @(posedge clk);
    if (!rst_n) sb.delete();
    else begin
      if (pop) begin
        if (sb.size() == 0) chk("sb_unexpected", 1, 0);
        else begin
          x = sb.pop_front();
          chk("sb_line", h.line, x.line);
          chk("sb_pixel", h.pix, x.pix);
          chk("sb_data", h.data, x.data);
          chk("sb_oob", h.oob, x.oob);
        end
      end
`ifdef IPM_OOB_DROP_EN
      if (acc && !e.oob) sb.push_back(e);
`else
      if (acc) sb.push_back(e);
`endif
    end
  end

  task automatic chk_zero(string n);
    chk({n, "_valid"}, int'(o_valid), 0);
    chk({n, "_ready"}, int'(o_ready), 0);
    chk({n, "_lut_en"}, int'(o_lut_en), 0);
    chk({n, "_lut_addr"}, int'(o_lut_addr), 0);
    chk({n, "_line"}, int'(o_line), 0);
    chk({n, "_pixel"}, int'(o_pixel), 0);
    chk({n, "_data"}, int'(o_data), 0);
    chk({n, "_oob"}, int'(o_oob), 0);
  endtask

  initial begin
    vec_t vt[12];
    int n, ev;
    vt[0]  = '{203, 403, 'h0F0, 0, -1, 203, 403, 'h0F0, 0};
    vt[1]  = '{250, 470, 'h123, 1, 100*1024+320, 100, 320, 'h123, 0};
    vt[2]  = '{10, 10, 'h555, 1, SENT, 0, 0, 0, 1};
    vt[3]  = '{40, 120, 'hABC, 2, -1, 40, 519, 'hABC, 0};
    vt[4]  = '{40, 120, 'hABC, 3, -1, 439, 120, 'hABC, 0};
    vt[5]  = '{40, 700, 'h321, 2, -1, 0, 0, 0, 1};
    vt[6]  = '{479, 639, 'h7FF, 0, -1, 479, 639, 'h7FF, 0};
    vt[7]  = '{480, 0, 'h111, 0, -1, 0, 0, 0, 1};
    vt[8]  = '{0, 0, 'h222, 1, 479*1024+639, 479, 639, 'h222, 0};
    vt[9]  = '{5, 5, 'h333, 1, 480*1024, 0, 0, 0, 1};
    vt[10] = '{500, 10, 'h444, 3, -1, 0, 0, 0, 1};
    vt[11] = '{0, 639, 'hFFF, 2, -1, 0, 0, 'hFFF, 0};

    i_valid = 1; im_p = 1; i_line = 9'd5; i_pixel = 10'd5;
    repeat (2) @(negedge clk);
    #1 chk_zero("rst");
    @(negedge clk);
    rst_n = 1; i_valid = 0;
    #1 chk("rdy_pre", int'(o_ready), 0);
    @(negedge clk);
    #1 chk("rdy_post", int'(o_ready), 1);
    i_ready = 1;

    foreach (vt[k]) begin
`ifdef IPM_OOB_DROP_EN
      ev = vt[k].eo ? 0 : 1;
`else
      ev = 1;
`endif
      @(negedge clk);
      i_valid = 1; i_line = 9'(vt[k].line); i_pixel = 10'(vt[k].pix);
      i_data = 12'(vt[k].data); im_p = 2'(vt[k].mode); lut_ovr = vt[k].lut;
      #2 chk("lut_en", int'(o_lut_en), int'(vt[k].mode == 1));
      if (vt[k].mode == 1) chk("lut_addr", int'(o_lut_addr), vt[k].line * 1024 + vt[k].pix);
      @(negedge clk);
      i_valid = 0;
      #2 chk("lat_n", int'(o_valid), 0);
      @(negedge clk);
      #2 chk("lat_n1", int'(o_valid), 0);
      @(negedge clk);
      #2 chk("vec_valid", int'(o_valid), ev);
      chk("vec_line", int'(o_line), vt[k].el);
      chk("vec_pixel", int'(o_pixel), vt[k].ep);
      chk("vec_data", int'(o_data), vt[k].ed);
      chk("vec_oob", int'(o_oob), ev ? vt[k].eo : 0);
      @(negedge clk);
      #2 chk("vec_pop", int'(o_valid), 0);
    end
    lut_ovr = -1;

    @(negedge clk);
    i_ready = 0; chk_credit = 1; n = 0;
    for (int k = 0; k < 10; k++) begin
      i_valid = 1; im_p = 0; i_line = 9'(k); i_pixel = 10'(2 * k); i_data = 12'('h100 + k);
      #2 if (o_ready) n++;
      @(negedge clk);
    end
    #2 chk("bp_accepted", n, D);
    chk("bp_ready", int'(o_ready), 0);
    repeat (3) begin
      chk("bp_hold_valid", int'(o_valid), 1);
      chk("bp_hold_line", int'(o_line), 0);
      chk("bp_hold_data", int'(o_data), 'h100);
      @(negedge clk); #2;
    end
    @(negedge clk);
    i_ready = 1;
    for (int k = 10; k < 22; k++) begin
      i_line = 9'(k); i_pixel = 10'(2 * k); i_data = 12'('h100 + k);
      @(negedge clk);
    end
    i_valid = 0;
    for (int t = 0; t < 50 && sb.size() != 0; t++) @(negedge clk);
    chk("bp_drain", sb.size(), 0);
    chk_credit = 0;

    @(negedge clk);
    i_ready = 0; i_valid = 1; im_p = 0;
    for (int k = 0; k < 3; k++) begin
      i_line = 9'(30 + k); i_pixel = 10'(60 + k); i_data = 12'('h200 + k);
      @(negedge clk);
    end
    im_p = 1;
    #2 chk("pre_rst_valid", int'(o_valid), 1);
    #1 rst_n = 0;
    #1 chk_zero("mid_rst");
    repeat (2) @(negedge clk);
    rst_n = 1; i_valid = 0; i_ready = 1;
    repeat (6) begin
      @(negedge clk);
      #2 chk("rst_stale", int'(o_valid), 0);
    end

    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      i_valid = $urandom_range(0, 9) < 7;
      i_ready = $urandom_range(0, 9) < 7;
      im_p = 2'($urandom_range(0, 3));
      i_line = 9'(($urandom_range(0, 9) == 0) ? $urandom_range(0, 511) : $urandom_range(0, 479));
      i_pixel = 10'(($urandom_range(0, 9) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 639));
      i_data = 12'($urandom_range(0, 4095));
    end
    @(negedge clk);
    i_valid = 0; i_ready = 1;
    for (int t = 0; t < 50 && sb.size() != 0; t++) @(negedge clk);
    chk("final_drain", sb.size(), 0);
    @(negedge clk);
    #2 chk("final_valid", int'(o_valid), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
